clr_inc_pipe: RTL and testbench
===============================

# clr_inc_pipe

Parametrised, multi-channel successor to the single-bit clear-capture-then-increment path. Each accepted beat carries `CHANNELS` lanes of `WIDTH` bits with a per-lane clear. Stage 1 captures each lane, or zero if its clear is set. Stage 2 adds a constant `INC`, wrapping or saturating. Both stages use valid/ready backpressure, and a counter tracks cleared lanes. It sits between a registered data source and any consumer that needs a sanitised, offset sample stream.

## Interface
Parameters:
- `WIDTH`, 8, lane data width (≥1)
- `CHANNELS`, 4, number of lanes (1..16)
- `INC`, 1, constant added in stage 2 (0 ≤ INC < 2^WIDTH)
- `SATURATE`, 0, 0 = modular wrap, 1 = clamp at 2^WIDTH−1

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  stage 1 can accept
- `in_data`  in  CHANNELS*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- `in_clr`  in  CHANNELS  per-lane clear; lane i captured as 0 when set
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  consumer accepts
- `out_data`  out  CHANNELS*WIDTH  lane results, same packing
- `out_ovf`  out  CHANNELS  per-lane carry-out of the stage-2 add
- `clr_count`  out  16  running count of cleared lanes in accepted beats

## Operation
- Input transfer: `in_valid && in_ready` on a clock edge.
- Stage 1, per lane: `s1_data[i] <= in_clr[i] ? 0 : in_data[i]`. `s1_valid` is set on transfer.
- Stage 2, per lane: `sum = {1'b0, s1_data[i]} + INC`, computed WIDTH+1 wide.
  - `out_ovf[i]` = sum[WIDTH], reported in both modes.
  - Lane result = sum[WIDTH-1:0] when SATURATE=0.
  - Lane result = all-ones when SATURATE=1 and the carry is set.
- Clear data never reaches the adder; a cleared lane always yields exactly `INC` with ovf=0.
- `clr_count` advances by popcount(`in_clr`) on each input transfer only.
  - `in_clr` is ignored when there is no transfer.
  - Saturates at 16'hFFFF and never wraps.
- Reset (asserted asynchronously, at any time, including mid-stream):
  - `s1_valid`, `out_valid`, all data, `out_ovf` and `clr_count` go to 0 immediately.
  - In-flight beats are discarded.
  - `in_ready` reads 1 once reset deasserts.
- Valid bits: each stage holds at most one beat.
  - Stage 2 loads when `s1_valid && (!out_valid || out_ready)`.
  - Stage 1 empties as stage 2 loads, and refills in the same cycle if an input transfer also occurs.

## Timing
- Latency: 2 cycles from input transfer to `out_valid`, with no stall.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- `in_ready = !s1_valid || !out_valid || out_ready`.
  - Combinational from `out_ready`; no combinational path from `in_valid`.
- While `out_valid && !out_ready`: `out_data`/`out_ovf` hold stable and `out_valid` stays high.
- Full pipeline (both stages valid, `out_ready`=0): `in_ready`=0 and the beat in stage 1 is held.
- Simultaneous output accept and input transfer when full:
  - Both occur in the same edge.
  - Stage 1 → stage 2 and input → stage 1 with no bubble.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0, `clr_count`=0.

## Structure
- Shared package `clr_inc_pkg` holds:
  - the `clr_count` width constant (16)
  - a popcount function
  - the lane-slice helper.
- One sub-module, `clr_capture_stage`: the stage-1 register bank.
  - Parameters `WIDTH` and `CHANNELS`.
  - Contains the clear mux, `s1_valid`, and its own valid/ready pair.
- The top instantiates `clr_capture_stage`, the stage-2 adder/saturate logic and the counter.

## Test plan
- Reset, then a single beat with WIDTH=8, CHANNELS=4, INC=1, SATURATE=0.
  - Stimulus: `in_data`=32'h04_03_02_01, `in_clr`=0.
  - Response: two cycles later `out_data`=32'h05_04_03_02, `out_ovf`=0, `clr_count`=0.
- Clear mix.
  - Stimulus: `in_data`=32'hFF_FF_FF_FF, `in_clr`=4'b0101.
  - Response: `out_data`=32'hFF_01_FF_01 would be wrong; correct result is lanes {0,2}=8'h01 and lanes {1,3}=8'h00 with ovf=4'b1010, i.e. `out_data`=32'h00_01_00_01, `out_ovf`=4'b1010, `clr_count`=2.
- SATURATE=1, INC=3, lane value 8'hFE.
  - Response: result 8'hFF with ovf=1.
  - Same lane value with SATURATE=0 gives 8'h01 with ovf=1.
- Backpressure.
  - Stimulus: stream beats 1..6 with `out_ready`=0 for cycles 3–6.
  - Response: `in_ready` drops once both stages hold beats; the output shows beats in order 1..6 with none lost or duplicated, and data stays stable during the stall.
- Counter saturation.
  - Stimulus: 16384 beats with all four lanes cleared, followed by 10 more.
  - Response: `clr_count` = 16'hFFFF and holds.
- Mid-stream reset.
  - Stimulus: assert `rst_n`=0 asynchronously while both stages are valid.
  - Response: `out_valid` and `clr_count` go to 0 before the next edge; the first beat after release emerges 2 cycles after its transfer.

Source files
------------

// File: rtl/clr_inc_pkg.sv
// clr_inc_pkg: shared constants and helpers for the clear-capture/increment pipeline
// Provides the clear-counter width, a lane popcount and the lane bit-offset helper.
package clr_inc_pkg;

    localparam int CNT_W  = 16;
    localparam int MAX_CH = 16;

    // Number of set bits; callers zero-extend narrower clear vectors to MAX_CH.
    function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int k = 0; k < MAX_CH; k++) n = n + {4'b0, v[k]};
        return n;
    endfunction

    // LSB position of a lane inside a packed multi-lane vector.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/clr_capture_stage.sv
// clr_capture_stage: stage-1 register bank, captures each lane or zero when its clear is set
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake
//   in_data_i, in_clr_i  packed lanes and per-lane clear
//   out_valid_o/out_ready_i downstream handshake towards stage 2
//   out_data_o           captured lanes
module clr_capture_stage
    import clr_inc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [CHANNELS*WIDTH-1:0] in_data_i,
    input  logic [CHANNELS-1:0]       in_clr_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [CHANNELS*WIDTH-1:0] out_data_o
);

    logic                      valid_q, valid_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d, capt;
    logic                      load;

    // Ready whenever empty or the held beat leaves on this same edge.
    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        localparam int LO = lane_lo(i, WIDTH);
        assign capt[LO +: WIDTH] = in_clr_i[i] ? '0 : in_data_i[LO +: WIDTH];
    end

    always_comb begin
        valid_d = load ? 1'b1 : (out_ready_i ? 1'b0 : valid_q);
        data_d  = load ? capt : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/clr_inc_pipe.sv
// clr_inc_pipe: two-stage multi-lane clear-capture then constant-increment pipeline
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake
//   in_data, in_clr        packed lanes (lane i at [i*WIDTH +: WIDTH]) and per-lane clear
//   out_valid/out_ready    output handshake
//   out_data, out_ovf      incremented lanes and per-lane carry-out
//   clr_count              saturating count of cleared lanes in accepted beats
module clr_inc_pipe
    import clr_inc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int INC      = 1,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_ovf,
    output logic [CNT_W-1:0]          clr_count
);

    localparam logic [WIDTH:0] INC_W = (WIDTH+1)'(INC);

    logic                      s1_valid, s2_ready, s2_load, xfer;
    logic [CHANNELS*WIDTH-1:0] s1_data, res;
    logic [CHANNELS-1:0]       ovf;
    logic [4:0]                pc;
    logic [CNT_W:0]            cnt_sum;

    logic                      out_valid_q, out_valid_d;
    logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
    logic [CHANNELS-1:0]       out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    // Stage 2 can take a beat when empty or when its current beat is consumed.
    assign s2_ready = !out_valid_q || out_ready;
    assign s2_load  = s1_valid && s2_ready;

    clr_capture_stage #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_s1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_clr_i    (in_clr),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_data)
    );

    // Sum is one bit wider so the carry is visible for both ovf and clamping.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_add
        localparam int LO = lane_lo(i, WIDTH);
        logic [WIDTH:0] sum;
        assign sum              = {1'b0, s1_data[LO +: WIDTH]} + INC_W;
        assign ovf[i]           = sum[WIDTH];
        assign res[LO +: WIDTH] = (SATURATE != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
    end

    assign xfer    = in_valid && in_ready;
    assign pc      = popcount(MAX_CH'(in_clr));
    assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(pc);

    always_comb begin
        out_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_data_d  = s2_load ? res : out_data_q;
        out_ovf_d   = s2_load ? ovf : out_ovf_q;
        cnt_d       = xfer ? (cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0]) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign clr_count = cnt_q;

endmodule

// File: tb/tb_clr_inc_pipe.sv
// tb_clr_inc_pipe: self-checking bench for clr_inc_pipe with a queue-based reference model
module tb_clr_inc_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_clr = '0;

    logic        ir [3];
    logic        ov [3];
    logic [31:0] od [3];
    logic [3:0]  oo [3];
    logic [15:0] cc [3];

    always #5 clk = ~clk;

    clr_inc_pipe #(.WIDTH(8), .CHANNELS(4), .INC(1), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_clr(in_clr), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_ovf(oo[0]), .clr_count(cc[0]));
    clr_inc_pipe #(.WIDTH(8), .CHANNELS(4), .INC(3), .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_clr(in_clr), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_ovf(oo[1]), .clr_count(cc[1]));
    clr_inc_pipe #(.WIDTH(8), .CHANNELS(4), .INC(3), .SATURATE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .in_clr(in_clr), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .out_ovf(oo[2]), .clr_count(cc[2]));

    typedef struct {
        logic [31:0] d [3];
        logic [3:0]  o [3];
        int          t;
    } exp_t;

    exp_t q[$];
    int   cnt = 0;
    int   edges = 0;
    int   passed = 0;
    int   total = 0;
    int   fails = 0;

    localparam int INCS [3] = '{1, 3, 3};
    localparam bit SATS [3] = '{1'b0, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Lane-wise arithmetic straight from the rules: clear -> 0, add, carry, optional clamp.
    task automatic model(input logic [31:0] d, input logic [3:0] c, input int inc, input bit sat,
                         output logic [31:0] r, output logic [3:0] o);
        r = '0;
        o = '0;
        for (int l = 0; l < 4; l++) begin
            int v, s;
            v = c[l] ? 0 : int'(d[l*8 +: 8]);
            s = v + inc;
            o[l] = (s > 255);
            r[l*8 +: 8] = (sat && s > 255) ? 8'hFF : 8'(s % 256);
        end
    endtask

    task automatic tick(output logic acc);
        logic ix, ox, hold, exp_ov;
        logic [31:0] pd;
        logic [3:0] po;
        exp_t e;
        #1;
        ix = in_valid && ir[0];
        ox = ov[0] && out_ready;
        exp_ov = 1'b0;
        if (q.size() > 0) exp_ov = (edges >= q[0].t + 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready%0d", k), ir[k], q.size() < 2 || out_ready);
            chk($sformatf("out_valid%0d", k), ov[k], exp_ov);
        end
        hold = ov[0] && !out_ready;
        pd = od[0];
        po = oo[0];
        if (ox) begin
            if (q.size() == 0) chk("spurious_out", ov[0], 1'b0);
            else begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("out_data%0d", k), od[k], e.d[k]);
                    chk($sformatf("out_ovf%0d", k), oo[k], e.o[k]);
                end
            end
        end
        if (ix) begin
            for (int k = 0; k < 3; k++) model(in_data, in_clr, INCS[k], SATS[k], e.d[k], e.o[k]);
            e.t = edges + 1;
            q.push_back(e);
            cnt = cnt + $countones(in_clr);
            if (cnt > 65535) cnt = 65535;
        end
        acc = ix;
        @(posedge clk);
        #1;
        edges++;
        for (int k = 0; k < 3; k++) chk($sformatf("clr_count%0d", k), cc[k], cnt);
        if (hold) begin
            chk("stall_valid", ov[0], 1'b1);
            chk("stall_data", od[0], pd);
            chk("stall_ovf", oo[0], po);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] c);
        logic a;
        in_valid = 1'b1;
        in_data = d;
        in_clr = c;
        tick(a);
        in_valid = 1'b0;
        in_clr = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic a, saw;
        int b, c;
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", ov[k], 1'b0);
            chk("rst_data", od[k], 32'h0);
            chk("rst_ovf", oo[k], 4'h0);
            chk("rst_cnt", cc[k], 16'h0);
            chk("rst_ready", ir[k], 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(32'h04030201, 4'b0000);
        tick(a);
        chk("beat1_data", od[0], 32'h05040302);
        chk("beat1_ovf", oo[0], 4'h0);
        chk("beat1_cnt", cc[0], 16'd0);

        send(32'hFFFFFFFF, 4'b0101);
        tick(a);
        chk("clrmix_data", od[0], 32'h00010001);
        chk("clrmix_ovf", oo[0], 4'b1010);
        chk("clrmix_cnt", cc[0], 16'd2);

        send(32'h000000FE, 4'b0000);
        tick(a);
        chk("sat_lane", {24'h0, od[1][7:0]}, 32'hFF);
        chk("sat_ovf", {31'h0, oo[1][0]}, 32'h1);
        chk("wrap_lane", {24'h0, od[2][7:0]}, 32'h01);
        chk("wrap_ovf", {31'h0, oo[2][0]}, 32'h1);
        tick(a);

        b = 1;
        c = 0;
        saw = 1'b0;
        while (b <= 6 && c < 40) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid = 1'b1;
            in_data = 32'(b);
            in_clr = '0;
            tick(a);
            if (a) b++;
            else saw = 1'b1;
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(a);
        chk("bp_all_sent", b, 7);
        chk("bp_ready_dropped", saw, 1'b1);
        chk("bp_drained", q.size(), 0);

        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_data = ($urandom_range(0, 3) == 0) ? 32'hFEFFFFFE : $urandom;
            in_clr = 4'($urandom & $urandom);
            tick(a);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(a);

        in_valid = 1'b1;
        in_clr = 4'hF;
        for (int i = 0; i < 16384 + 10; i++) tick(a);
        in_valid = 1'b0;
        in_clr = '0;
        chk("cnt_sat", cc[0], 16'hFFFF);
        for (int i = 0; i < 3; i++) tick(a);
        chk("cnt_hold", cc[0], 16'hFFFF);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h11223344;
        for (int i = 0; i < 4; i++) tick(a);
        in_valid = 1'b0;
        chk("full_valid", ov[0], 1'b1);
        chk("full_ready", ir[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("arst_valid", ov[k], 1'b0);
            chk("arst_cnt", cc[k], 16'h0);
            chk("arst_data", od[k], 32'h0);
        end
        q.delete();
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", ir[0], 1'b1);
        out_ready = 1'b1;
        send(32'h10203040, 4'b0010);
        chk("post_rst_lat1", ov[0], 1'b0);
        tick(a);
        chk("post_rst_valid", ov[0], 1'b1);
        chk("post_rst_data", od[0], 32'h11210141);
        for (int i = 0; i < 3; i++) tick(a);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
